// File: rtl/stk_arb_if.sv
// Command/response bundle between requesting engines and the shared stack arbiter.
interface stk_arb_if #(
    parameter int unsigned ENGS_N = 4,
    parameter int unsigned W      = 128,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [ENGS_N-1:0][2:0]   i_cmd_opcode;
    logic [ENGS_N-1:0][W-1:0] i_cmd_dat;
    logic [ENGS_N-1:0]        o_cmd_ack;
    logic [ENGS_N-1:0]        o_rsp_vld;
    logic [W-1:0]             o_rsp_dat;
    logic [CW-1:0]            o_cnt;
    logic                     o_err_ovf;
    logic                     o_err_udf;

    // Engine side: issues commands, receives grants and responses.
    modport master (
        output i_cmd_opcode, i_cmd_dat,
        input  o_cmd_ack, o_rsp_vld, o_rsp_dat, o_cnt, o_err_ovf, o_err_udf
    );

    // Arbiter side.
    modport slave (
        input  i_cmd_opcode, i_cmd_dat,
        output o_cmd_ack, o_rsp_vld, o_rsp_dat, o_cnt, o_err_ovf, o_err_udf
    );
endinterface

// File: rtl/stk_arb.sv
// Shared LIFO stack with round-robin arbitration among ENGS_N command ports.
// One command is consumed per cycle; POP/PUSHPOP responses appear one cycle later.
module stk_arb #(
    parameter int unsigned ENGS_N = 4,
    parameter int unsigned W      = 128,
    parameter int unsigned DEPTH  = 8
) (
    input  logic     clk,
    input  logic     arst,
    stk_arb_if.slave bus
);
    localparam int unsigned PW = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_PUSHPOP = 3'd3;
    localparam logic [2:0] OP_CLR     = 3'd4;

    logic [PW-1:0]     last;
    logic [ENGS_N-1:0] req;
    logic              gnt;
    logic [PW-1:0]     sel;
    logic [ENGS_N-1:0] ack_c;
    int                idx;

    logic [W-1:0]      mem [DEPTH];
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [ENGS_N-1:0] rsp_vld, rsp_vld_nxt;
    logic [W-1:0]      rsp_dat, rsp_dat_nxt;
    logic              err_ovf, err_ovf_nxt;
    logic              err_udf, err_udf_nxt;

    logic [2:0]        op;
    logic              full, empty;
    logic [AW-1:0]     top_idx;
    logic [W-1:0]      top;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [W-1:0]      wdat;

    // A port requests only with a defined non-NOP opcode; 5..7 are ignored.
    always_comb begin
        for (int i = 0; i < int'(ENGS_N); i++) begin
            req[i] = (bus.i_cmd_opcode[i] >= OP_PUSH) && (bus.i_cmd_opcode[i] <= OP_CLR);
        end
    end

    // Round-robin pick starting just after the last granted port; nothing during reset.
    always_comb begin
        gnt = 1'b0;
        sel = '0;
        idx = 0;
        for (int k = 1; k <= int'(ENGS_N); k++) begin
            idx = (int'(last) + k) % int'(ENGS_N);
            if (!gnt && req[PW'(idx)]) begin
                gnt = 1'b1;
                sel = PW'(idx);
            end
        end
        if (arst) begin
            gnt = 1'b0;
        end
    end

    assign ack_c         = gnt ? (ENGS_N'(1) << sel) : '0;
    assign bus.o_cmd_ack = ack_c;

    assign op      = gnt ? bus.i_cmd_opcode[sel] : OP_NOP;
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign top_idx = AW'(cnt - CW'(1));
    assign top     = mem[top_idx];

    // Stack update and response generation for the granted command.
    always_comb begin
        cnt_nxt     = cnt;
        rsp_vld_nxt = '0;
        rsp_dat_nxt = '0;
        err_ovf_nxt = 1'b0;
        err_udf_nxt = 1'b0;
        we          = 1'b0;
        waddr       = AW'(cnt);
        wdat        = bus.i_cmd_dat[sel];
        case (op)
            OP_PUSH: begin
                if (!full) begin
                    we      = 1'b1;
                    cnt_nxt = cnt + CW'(1);
                end else begin
                    err_ovf_nxt = 1'b1;
                end
            end
            OP_POP: begin
                rsp_vld_nxt = ack_c;
                if (!empty) begin
                    cnt_nxt     = cnt - CW'(1);
                    rsp_dat_nxt = top;
                end else begin
                    err_udf_nxt = 1'b1;
                end
            end
            OP_PUSHPOP: begin
                rsp_vld_nxt = ack_c;
                we          = 1'b1;
                if (!empty) begin
                    waddr       = top_idx;
                    rsp_dat_nxt = top;
                end else begin
                    cnt_nxt     = CW'(1);
                    err_udf_nxt = 1'b1;
                end
            end
            OP_CLR: begin
                cnt_nxt = '0;
            end
            default: ;
        endcase
    end

    // Control and response registers; reset discards any pending response.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            last    <= PW'(ENGS_N - 1);
            cnt     <= '0;
            rsp_vld <= '0;
            rsp_dat <= '0;
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (gnt) begin
                last <= sel;
            end
            cnt     <= cnt_nxt;
            rsp_vld <= rsp_vld_nxt;
            rsp_dat <= rsp_dat_nxt;
            err_ovf <= err_ovf_nxt;
            err_udf <= err_udf_nxt;
        end
    end

    // Stack storage needs no reset; occupancy alone defines valid entries.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdat;
        end
    end

    assign bus.o_cnt     = cnt;
    assign bus.o_rsp_vld = rsp_vld;
    assign bus.o_rsp_dat = rsp_dat;
    assign bus.o_err_ovf = err_ovf;
    assign bus.o_err_udf = err_udf;
endmodule

// File: tb/tb_stk_arb.sv
// Bench for stk_arb: per-port command queues, a queue-based stack model, directed and random scenarios.
module tb_stk_arb;
    localparam int unsigned ENGS_N = 4;
    localparam int unsigned W      = 128;
    localparam int unsigned DEPTH  = 8;

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] d;
    } cmd_t;

    logic clk = 1'b0;
    logic arst;

    always #5 clk = ~clk;

    stk_arb_if #(.ENGS_N(ENGS_N), .W(W), .DEPTH(DEPTH)) bus ();

    stk_arb #(.ENGS_N(ENGS_N), .W(W), .DEPTH(DEPTH)) u_dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    cmd_t         pq [ENGS_N][$];
    logic [2:0]   idle_op [ENGS_N];
    logic [W-1:0] stk [$];
    int           last;
    int           ack_log [$];
    logic [W-1:0] rsp_log [$];
    int           ovf_seen;
    int           udf_seen;
    int           n_cmp = 0;
    int           n_bad = 0;

    function automatic logic [W-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void model_reset();
        stk.delete();
        last = int'(ENGS_N) - 1;
        ack_log.delete();
        rsp_log.delete();
        for (int p = 0; p < int'(ENGS_N); p++) begin
            pq[p].delete();
            idle_op[p] = 3'd0;
        end
    endfunction

    function automatic void enq(input int p, input logic [2:0] op, input logic [W-1:0] d);
        cmd_t c;
        c.op = op;
        c.d  = d;
        pq[p].push_back(c);
    endfunction

    function automatic int pick();
        for (int k = 1; k <= int'(ENGS_N); k++) begin
            int p;
            p = (last + k) % int'(ENGS_N);
            if (pq[p].size() > 0) return p;
        end
        return -1;
    endfunction

    function automatic bit busy();
        for (int p = 0; p < int'(ENGS_N); p++) begin
            if (pq[p].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive();
        for (int p = 0; p < int'(ENGS_N); p++) begin
            if (pq[p].size() > 0) begin
                bus.i_cmd_opcode[p] = pq[p][0].op;
                bus.i_cmd_dat[p]    = pq[p][0].d;
            end else begin
                bus.i_cmd_opcode[p] = idle_op[p];
                bus.i_cmd_dat[p]    = rnd();
            end
        end
    endtask

    // One clock: present heads of queues, check the grant, advance the model, check registered outputs.
    task automatic cycle();
        int                g;
        cmd_t              c;
        logic [ENGS_N-1:0] e_ack;
        logic [ENGS_N-1:0] e_vld;
        logic [W-1:0]      e_dat;
        logic              e_ovf;
        logic              e_udf;
        drive();
        @(negedge clk);
        g     = pick();
        e_ack = (g >= 0) ? ENGS_N'(1 << g) : '0;
        n_cmp++;
        if (bus.o_cmd_ack !== e_ack) begin
            n_bad++;
            $display("FAIL cmd_ack @%0t: got %b, expected %b", $time, bus.o_cmd_ack, e_ack);
        end
        e_vld = '0;
        e_dat = '0;
        e_ovf = 1'b0;
        e_udf = 1'b0;
        if (g >= 0) begin
            c    = pq[g].pop_front();
            last = g;
            ack_log.push_back(g);
            case (c.op)
                3'd1: begin
                    if (stk.size() < int'(DEPTH)) stk.push_back(c.d);
                    else e_ovf = 1'b1;
                end
                3'd2: begin
                    e_vld = e_ack;
                    if (stk.size() > 0) e_dat = stk.pop_back();
                    else e_udf = 1'b1;
                end
                3'd3: begin
                    e_vld = e_ack;
                    if (stk.size() > 0) begin
                        e_dat = stk[stk.size() - 1];
                        stk[stk.size() - 1] = c.d;
                    end else begin
                        stk.push_back(c.d);
                        e_udf = 1'b1;
                    end
                end
                3'd4: stk.delete();
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.o_rsp_vld !== e_vld) begin
            n_bad++;
            $display("FAIL rsp_vld @%0t: got %b, expected %b", $time, bus.o_rsp_vld, e_vld);
        end
        n_cmp++;
        if (bus.o_rsp_dat !== e_dat) begin
            n_bad++;
            $display("FAIL rsp_dat @%0t: got %0h, expected %0h", $time, bus.o_rsp_dat, e_dat);
        end
        n_cmp++;
        if (bus.o_err_ovf !== e_ovf) begin
            n_bad++;
            $display("FAIL err_ovf @%0t: got %b, expected %b", $time, bus.o_err_ovf, e_ovf);
        end
        n_cmp++;
        if (bus.o_err_udf !== e_udf) begin
            n_bad++;
            $display("FAIL err_udf @%0t: got %b, expected %b", $time, bus.o_err_udf, e_udf);
        end
        n_cmp++;
        if (bus.o_cnt !== 4'(stk.size())) begin
            n_bad++;
            $display("FAIL cnt @%0t: got %0d, expected %0d", $time, bus.o_cnt, stk.size());
        end
        if (bus.o_err_ovf === 1'b1) ovf_seen++;
        if (bus.o_err_udf === 1'b1) udf_seen++;
        if (e_vld != '0) rsp_log.push_back(e_dat);
    endtask

    task automatic run_until_idle(input int max, input string name);
        int n = 0;
        while (busy() && n < max) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (busy()) begin
            n_bad++;
            $display("FAIL %s timeout: commands still pending after %0d cycles, expected none", name, n);
            for (int p = 0; p < int'(ENGS_N); p++) pq[p].delete();
        end
    endtask

    task automatic test_reset();
        arst = 1'b1;
        model_reset();
        for (int p = 0; p < int'(ENGS_N); p++) enq(p, 3'd1, rnd());
        drive();
        repeat (3) begin
            #1;
            n_cmp++;
            if (bus.o_cmd_ack !== '0) begin
                n_bad++;
                $display("FAIL reset_ack: got %b, expected 0000", bus.o_cmd_ack);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if ({bus.o_rsp_vld, bus.o_rsp_dat, bus.o_cnt, bus.o_err_ovf, bus.o_err_udf} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs: vld=%b dat=%0h cnt=%0d ovf=%b udf=%b, expected all 0",
                         bus.o_rsp_vld, bus.o_rsp_dat, bus.o_cnt, bus.o_err_ovf, bus.o_err_udf);
            end
        end
        model_reset();
        drive();
        arst = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic test_rr_push();
        for (int p = 0; p < int'(ENGS_N); p++) enq(p, 3'd1, W'(10 + p));
        ack_log.delete();
        run_until_idle(10, "rr_push");
        for (int i = 0; i < 4; i++) begin
            int got;
            got = (ack_log.size() > i) ? ack_log[i] : -1;
            n_cmp++;
            if (got !== i) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got port %0d, expected port %0d", i, got, i);
            end
        end
        n_cmp++;
        if (bus.o_cnt !== 4'd4) begin
            n_bad++;
            $display("FAIL rr_cnt: got %0d, expected 4", bus.o_cnt);
        end
    endtask

    task automatic test_pop_order();
        logic [W-1:0] want [4];
        want[0] = W'(13);
        want[1] = W'(12);
        want[2] = W'(11);
        want[3] = W'(10);
        rsp_log.delete();
        repeat (4) enq(2, 3'd2, rnd());
        run_until_idle(10, "pop_order");
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] got;
            got = (rsp_log.size() > i) ? rsp_log[i] : 'x;
            n_cmp++;
            if (got !== want[i]) begin
                n_bad++;
                $display("FAIL pop_data[%0d]: got %0h, expected %0h", i, got, want[i]);
            end
        end
        n_cmp++;
        if (bus.o_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL pop_cnt: got %0d, expected 0", bus.o_cnt);
        end
    endtask

    task automatic test_overflow();
        ovf_seen = 0;
        for (int i = 0; i < 9; i++) enq(1, 3'd1, W'(i));
        run_until_idle(15, "overflow");
        n_cmp++;
        if (ovf_seen !== 1) begin
            n_bad++;
            $display("FAIL ovf_pulses: got %0d, expected 1", ovf_seen);
        end
        n_cmp++;
        if (bus.o_cnt !== 4'd8) begin
            n_bad++;
            $display("FAIL ovf_cnt: got %0d, expected 8", bus.o_cnt);
        end
        rsp_log.delete();
        enq(1, 3'd2, rnd());
        run_until_idle(5, "ovf_pop");
        n_cmp++;
        if (rsp_log.size() != 1 || rsp_log[0] !== W'(7)) begin
            n_bad++;
            $display("FAIL ovf_pop_data: got %0d responses (first %0h), expected one with 7",
                     rsp_log.size(), (rsp_log.size() > 0) ? rsp_log[0] : '0);
        end
    endtask

    task automatic test_underflow();
        enq(3, 3'd4, rnd());
        run_until_idle(5, "clr");
        udf_seen = 0;
        rsp_log.delete();
        enq(3, 3'd2, rnd());
        run_until_idle(5, "underflow");
        n_cmp++;
        if (udf_seen !== 1) begin
            n_bad++;
            $display("FAIL udf_pulses: got %0d, expected 1", udf_seen);
        end
        n_cmp++;
        if (rsp_log.size() != 1 || rsp_log[0] !== '0) begin
            n_bad++;
            $display("FAIL udf_rsp: got %0d responses, expected one with data 0", rsp_log.size());
        end
    endtask

    task automatic test_pushpop();
        rsp_log.delete();
        enq(0, 3'd1, W'(5));
        enq(0, 3'd1, W'(6));
        enq(0, 3'd3, W'(9));
        enq(0, 3'd2, rnd());
        run_until_idle(10, "pushpop");
        n_cmp++;
        if (rsp_log.size() != 2 || rsp_log[0] !== W'(6) || rsp_log[1] !== W'(9)) begin
            n_bad++;
            $display("FAIL pushpop_rsp: got %0d responses, expected 6 then 9", rsp_log.size());
        end
        n_cmp++;
        if (bus.o_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL pushpop_cnt: got %0d, expected 1", bus.o_cnt);
        end
    endtask

    task automatic test_random();
        logic [2:0] idle_set [4];
        idle_set[0] = 3'd0;
        idle_set[1] = 3'd5;
        idle_set[2] = 3'd6;
        idle_set[3] = 3'd7;
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < int'(ENGS_N); p++) begin
                idle_op[p] = idle_set[$urandom_range(0, 3)];
                if (pq[p].size() == 0 && $urandom_range(0, 9) < 5) begin
                    int r;
                    r = $urandom_range(0, 19);
                    if (r < 8) enq(p, 3'd1, rnd());
                    else if (r < 14) enq(p, 3'd2, rnd());
                    else if (r < 19) enq(p, 3'd3, rnd());
                    else enq(p, 3'd4, rnd());
                end
            end
            cycle();
        end
        run_until_idle(50, "random_drain");
        for (int p = 0; p < int'(ENGS_N); p++) idle_op[p] = 3'd0;
    endtask

    task automatic test_mid_reset();
        enq(2, 3'd4, rnd());
        for (int i = 0; i < 5; i++) enq(2, 3'd1, rnd());
        run_until_idle(10, "mid_reset_fill");
        for (int i = 0; i < 6; i++) begin
            enq(0, 3'd2, rnd());
            enq(1, 3'd2, rnd());
        end
        ack_log.delete();
        repeat (4) cycle();
        for (int i = 0; i < 4; i++) begin
            int got;
            got = (ack_log.size() > i) ? ack_log[i] : -1;
            n_cmp++;
            if (got !== (i % 2)) begin
                n_bad++;
                $display("FAIL alt_order[%0d]: got port %0d, expected port %0d", i, got, i % 2);
            end
        end
        arst = 1'b1;
        #1;
        n_cmp++;
        if (bus.o_cmd_ack !== '0 || bus.o_rsp_vld !== '0 || bus.o_rsp_dat !== '0 || bus.o_cnt !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: ack=%b vld=%b dat=%0h cnt=%0d, expected all 0",
                     bus.o_cmd_ack, bus.o_rsp_vld, bus.o_rsp_dat, bus.o_cnt);
        end
        @(posedge clk);
        #1;
        model_reset();
        drive();
        arst = 1'b0;
        repeat (3) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        ovf_seen = 0;
        udf_seen = 0;
        test_reset();
        test_rr_push();
        test_pop_order();
        test_overflow();
        test_underflow();
        test_pushpop();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
